// File: rtl/axi_calc_engine.sv
// AXI4-Lite slave calculator: add/sub/logic in one cycle, iterative shift-add
// multiply and restoring divide at one bit per cycle, with done status and irq.
module axi_calc_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              irq
);

    localparam int W  = C_S_AXI_DATA_WIDTH;
    localparam int SW = W / 8;
    localparam int CW = $clog2(W);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_OPA    = 3'd1;
    localparam logic [2:0] REG_OPB    = 3'd2;
    localparam logic [2:0] REG_RES_LO = 3'd3;
    localparam logic [2:0] REG_RES_HI = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    // AXI channel state
    logic          aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
    logic [1:0]    b_resp_q;
    logic [W-1:0]  r_data_q;

    // Software-visible registers
    logic [3:0]    ctrl_op;
    logic          ctrl_irq_en;
    logic [W-1:0]  opa, opb;
    logic [W-1:0]  res_lo, res_hi;
    logic          done, div0, ovf;

    // Engine
    state_t        state;
    logic          start_pend, go_q;
    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [W-1:0]  a_q, b_q, acc_hi, acc_lo;

    logic [2:0]    wr_idx;
    logic          wr_fire, wr_start, wr_reject, wr_ok, w1c_done, b_hs, busy;
    logic [W-1:0]  rd_word;

    logic [W:0]    add_full, sub_full, mul_sum, div_r;
    logic          div_ge;
    logic [W-1:0]  mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic [W-1:0]  res_lo_n, res_hi_n;
    logic          ovf_n, div0_n;

    // Only addr[4:2] selects a register; the byte offset is don't-care.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [W-1:0] merge_bytes(input logic [W-1:0] old_val,
                                                 input logic [W-1:0] new_val,
                                                 input logic [SW-1:0] strb);
        logic [W-1:0] r;
        r = old_val;
        for (int i = 0; i < SW; i++)
            if (strb[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        return r;
    endfunction

    assign busy = (state == S_EXEC);
    assign b_hs = b_valid_q & S_AXI_BREADY;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_idx    = S_AXI_AWADDR[4:2];
        wr_fire   = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
        wr_start  = (wr_idx == REG_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[4];
        // A launch still in flight counts as busy so operands cannot slip in underneath it.
        wr_reject = (busy | go_q | start_pend) &
                    ((wr_idx == REG_OPA) | (wr_idx == REG_OPB) | wr_start);
        wr_ok     = wr_fire & ~wr_reject;
        w1c_done  = wr_ok & (wr_idx == REG_STATUS) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
    end

    // Write channel and writable registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_ready_q  <= 1'b0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= 2'b00;
            ctrl_op     <= '0;
            ctrl_irq_en <= 1'b0;
            opa         <= '0;
            opb         <= '0;
            start_pend  <= 1'b0;
        end else begin
            aw_ready_q <= ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~b_valid_q;
            if (wr_fire) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_reject ? 2'b10 : 2'b00;
            end else if (b_hs) begin
                b_valid_q <= 1'b0;
            end

            if (wr_ok) begin
                case (wr_idx)
                    REG_CTRL: begin
                        if (S_AXI_WSTRB[0]) ctrl_op     <= S_AXI_WDATA[3:0];
                        if (S_AXI_WSTRB[1]) ctrl_irq_en <= S_AXI_WDATA[8];
                    end
                    REG_OPA: opa <= merge_bytes(opa, S_AXI_WDATA, S_AXI_WSTRB);
                    REG_OPB: opb <= merge_bytes(opb, S_AXI_WDATA, S_AXI_WSTRB);
                    default: ;
                endcase
            end

            // The op launches only once software has seen the write response.
            if (wr_ok && wr_start) start_pend <= 1'b1;
            else if (b_hs)         start_pend <= 1'b0;
        end
    end

    // Datapath: one iteration step for MUL/DIV plus the final result select
    always_comb begin
        add_full = {1'b0, a_q} + {1'b0, b_q};
        sub_full = {1'b0, a_q} - {1'b0, b_q};

        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
        mul_hi_n = mul_sum[W:1];
        mul_lo_n = {mul_sum[0], acc_lo[W-1:1]};

        div_r    = {acc_hi, acc_lo[W-1]};
        div_ge   = (div_r >= {1'b0, b_q});
        div_hi_n = div_ge ? W'(div_r - {1'b0, b_q}) : div_r[W-1:0];
        div_lo_n = {acc_lo[W-2:0], div_ge};

        res_lo_n = '0;
        res_hi_n = '0;
        ovf_n    = 1'b0;
        div0_n   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_lo_n = add_full[W-1:0];
                res_hi_n = W'(add_full[W]);
                ovf_n    = (a_q[W-1] == b_q[W-1]) && (add_full[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                res_lo_n = sub_full[W-1:0];
                res_hi_n = W'(sub_full[W]);
                ovf_n    = (a_q[W-1] != b_q[W-1]) && (sub_full[W-1] != a_q[W-1]);
            end
            OP_MUL: begin
                res_lo_n = mul_lo_n;
                res_hi_n = mul_hi_n;
                ovf_n    = |mul_hi_n;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_lo_n = '1;
                    res_hi_n = a_q;
                    div0_n   = 1'b1;
                end else begin
                    res_lo_n = div_lo_n;
                    res_hi_n = div_hi_n;
                end
            end
            OP_AND:  res_lo_n = a_q & b_q;
            OP_OR:   res_lo_n = a_q | b_q;
            OP_XOR:  res_lo_n = a_q ^ b_q;
            default: ovf_n    = 1'b1;
        endcase
    end

    // Engine FSM
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state  <= S_IDLE;
            go_q   <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            res_lo <= '0;
            res_hi <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            go_q <= b_hs & start_pend;

            // NOTE: a later non-blocking assignment to the same bit wins, so the
            // completion below overrides this W1C when both happen in one cycle.
            if (w1c_done) done <= 1'b0;

            case (state)
                S_EXEC: begin
                    if (cnt == '0) begin
                        res_lo <= res_lo_n;
                        res_hi <= res_hi_n;
                        ovf    <= ovf_n;
                        div0   <= div0_n;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        acc_hi <= (op_q == OP_MUL) ? mul_hi_n : div_hi_n;
                        acc_lo <= (op_q == OP_MUL) ? mul_lo_n : div_lo_n;
                    end
                end
                default: begin
                    if (go_q) begin
                        op_q   <= ctrl_op;
                        a_q    <= opa;
                        b_q    <= opb;
                        acc_hi <= '0;
                        acc_lo <= (ctrl_op == OP_MUL) ? opb : opa;
                        cnt    <= ((ctrl_op == OP_MUL) || (ctrl_op == OP_DIV && opb != '0))
                                  ? CW'(W - 1) : '0;
                        done   <= 1'b0;
                        div0   <= 1'b0;
                        ovf    <= 1'b0;
                        state  <= S_EXEC;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Read channel
    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[4:2])
            REG_CTRL: begin
                rd_word[3:0] = ctrl_op;
                rd_word[8]   = ctrl_irq_en;
            end
            REG_OPA:    rd_word = opa;
            REG_OPB:    rd_word = opb;
            REG_RES_LO: rd_word = res_lo;
            REG_RES_HI: rd_word = res_hi;
            REG_STATUS: rd_word[3:0] = {ovf, div0, done, busy};
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            ar_ready_q <= ~ar_ready_q & S_AXI_ARVALID & ~r_valid_q;
            if (ar_ready_q && S_AXI_ARVALID) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_word;
            end else if (r_valid_q && S_AXI_RREADY) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = 2'b00;
    assign irq           = done & ctrl_irq_en;

endmodule
